rle_job_sched: RTL and testbench

//  Job scheduler for the rle engine. Queues compression jobs
//  (message_addr, message_size, rle_addr, tag) from a host and launches them on
//  the single rle instance one at a time. It waits for the engine's level done,

---
 rtl/rle_job_sched.sv | 213 +++++++++++++++++++++
 tb/tb_rle_job_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_job_sched.sv
// Purpose: queues host compression jobs and runs them one at a time on the single rle engine.
// Latency: rle_start is high 2 cycles after the accepting cycle; a size-0 job completes 2 cycles after it.
// Backpressure: job_ready drops while the queue is full; a stalled completion blocks launches, not pushes.
// Optional watchdog on WAIT is compiled in with `define RLE_SCHED_TIMEOUT_EN.
module rle_job_sched #(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [31:0]                job_msg_addr,
    input  logic [31:0]                job_msg_size,
    input  logic [31:0]                job_rle_addr,
    input  logic [TAG_W-1:0]           job_tag,
    output logic                       rle_nreset,
    output logic                       rle_start,
    output logic [31:0]                rle_message_addr,
    output logic [31:0]                rle_message_size,
    output logic [31:0]                rle_rle_addr,
    input  logic                       rle_done,
    input  logic [31:0]                rle_size_in,
    output logic                       cmp_valid,
    input  logic                       cmp_ready,
    output logic [TAG_W-1:0]           cmp_tag,
    output logic [31:0]                cmp_rle_size,
    output logic                       cmp_err,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     queue_count,
    output logic [15:0]                jobs_done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Bad parameter sets are rejected at elaboration rather than producing a broken queue.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("rle_job_sched: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
    end

    typedef struct packed {
        logic [31:0]      msg_addr;
        logic [31:0]      msg_size;
        logic [31:0]      rle_addr;
        logic [TAG_W-1:0] tag;
    } job_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_WAIT,
        S_CMPL,
        S_RECOV
    } state_t;

    job_t             q_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    job_t             job_in;
    job_t             head;
    logic             full;
    logic             push;
    logic             pop;
    state_t           state;
    logic [TAG_W-1:0] cur_tag;

`ifdef RLE_SCHED_TIMEOUT_EN
    logic [31:0]      wd_cnt;
    logic             rec_cnt;
    logic             cmp_err_q;
`endif

    assign job_in      = '{msg_addr: job_msg_addr, msg_size: job_msg_size,
                           rle_addr: job_rle_addr, tag: job_tag};
    assign head        = q_mem[rd_ptr];
    assign full        = (count == CNT_W'(DEPTH));
    // Held low during reset so the host sees job_ready rise on the first free cycle.
    assign job_ready   = ~reset & ~full;
    assign push        = job_valid & job_ready;
    assign pop         = (state == S_IDLE) && (count != '0);
    assign queue_count = count;
    assign busy        = (state != S_IDLE) || (count != '0);
    // The engine is only held in reset by the host reset or by watchdog recovery.
    assign rle_nreset  = ~reset & (state != S_RECOV);

`ifdef RLE_SCHED_TIMEOUT_EN
    assign cmp_err = cmp_err_q;
`else
    assign cmp_err = 1'b0;
`endif

    // Job queue: wrapping pointers, simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_mem[wr_ptr] <= job_in;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Launch/complete sequencer; every engine-facing and host-facing output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            rle_start        <= 1'b0;
            rle_message_addr <= '0;
            rle_message_size <= '0;
            rle_rle_addr     <= '0;
            cur_tag          <= '0;
            cmp_valid        <= 1'b0;
            cmp_tag          <= '0;
            cmp_rle_size     <= '0;
            jobs_done        <= '0;
`ifdef RLE_SCHED_TIMEOUT_EN
            wd_cnt           <= '0;
            rec_cnt          <= 1'b0;
            cmp_err_q        <= 1'b0;
`endif
        end else begin
            rle_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        rle_message_addr <= head.msg_addr;
                        rle_message_size <= head.msg_size;
                        rle_rle_addr     <= head.rle_addr;
                        cur_tag          <= head.tag;
                        if (head.msg_size == 32'd0) begin
                            // Nothing to compress: report an empty result without touching the engine.
                            state        <= S_CMPL;
                            cmp_valid    <= 1'b1;
                            cmp_tag      <= head.tag;
                            cmp_rle_size <= '0;
`ifdef RLE_SCHED_TIMEOUT_EN
                            cmp_err_q    <= 1'b0;
`endif
                        end else begin
                            state     <= S_LAUNCH;
                            rle_start <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    state <= S_ARM;
                end
                S_ARM: begin
                    // done may still be high from the previous job here, so it is not looked at.
                    state <= S_WAIT;
`ifdef RLE_SCHED_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (rle_done) begin
                        state        <= S_CMPL;
                        cmp_valid    <= 1'b1;
                        cmp_tag      <= cur_tag;
                        cmp_rle_size <= rle_size_in;
`ifdef RLE_SCHED_TIMEOUT_EN
                        cmp_err_q    <= 1'b0;
                    end else if (wd_cnt == 32'(TIMEOUT_CYC - 1)) begin
                        state   <= S_RECOV;
                        rec_cnt <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
`endif
                    end
                end
`ifdef RLE_SCHED_TIMEOUT_EN
                S_RECOV: begin
                    // Two cycles of engine reset, then report the job as aborted.
                    if (rec_cnt) begin
                        state        <= S_CMPL;
                        cmp_valid    <= 1'b1;
                        cmp_tag      <= cur_tag;
                        cmp_rle_size <= '0;
                        cmp_err_q    <= 1'b1;
                    end else begin
                        rec_cnt <= 1'b1;
                    end
                end
`endif
                S_CMPL: begin
                    if (cmp_ready) begin
                        state     <= S_IDLE;
                        cmp_valid <= 1'b0;
                        jobs_done <= jobs_done + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rle_job_sched.sv
// Directed bench for rle_job_sched with a behavioural rle engine model.
// Engine model: done drops the cycle after start, rises after a set delay with size = message_size/2.
// Watchdog steps run only when RLE_SCHED_TIMEOUT_EN is defined (TIMEOUT_CYC=100).
module tb_rle_job_sched;

`ifdef RLE_SCHED_TIMEOUT_EN
    localparam int TB_TO = 100;
`else
    localparam int TB_TO = 65536;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_msg_addr = '0;
    logic [31:0] job_msg_size = '0;
    logic [31:0] job_rle_addr = '0;
    logic [3:0]  job_tag = '0;
    logic        rle_nreset;
    logic        rle_start;
    logic [31:0] rle_message_addr;
    logic [31:0] rle_message_size;
    logic [31:0] rle_rle_addr;
    logic        rle_done = 1'b0;
    logic [31:0] rle_size_in = '0;
    logic        cmp_valid;
    logic        cmp_ready = 1'b0;
    logic [3:0]  cmp_tag;
    logic [31:0] cmp_rle_size;
    logic        cmp_err;
    logic        busy;
    logic [2:0]  queue_count;
    logic [15:0] jobs_done;

    int n_cmp = 0;
    int n_err = 0;

    rle_job_sched #(.DEPTH(4), .TAG_W(4), .TIMEOUT_CYC(TB_TO)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_msg_addr(job_msg_addr), .job_msg_size(job_msg_size),
        .job_rle_addr(job_rle_addr), .job_tag(job_tag),
        .rle_nreset(rle_nreset), .rle_start(rle_start),
        .rle_message_addr(rle_message_addr), .rle_message_size(rle_message_size),
        .rle_rle_addr(rle_rle_addr), .rle_done(rle_done), .rle_size_in(rle_size_in),
        .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_tag(cmp_tag),
        .cmp_rle_size(cmp_rle_size), .cmp_err(cmp_err), .busy(busy),
        .queue_count(queue_count), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    // Engine model, evaluated mid-cycle so it never races the DUT's sampling edge.
    int  mdl_delay = 40;
    bit  mdl_hang = 1'b0;
    int  mdl_cnt = -1;
    bit  mdl_clr = 1'b0;
    int  start_cnt = 0;
    int  max_count = 0;
    always @(negedge clk) begin
        if (rle_nreset !== 1'b1) begin
            rle_done = 1'b0;
            mdl_cnt  = -1;
            mdl_clr  = 1'b0;
        end else begin
            if (mdl_clr) begin
                rle_done = 1'b0;
                mdl_clr  = 1'b0;
                mdl_cnt  = mdl_delay;
            end else if (mdl_cnt > 0) begin
                mdl_cnt--;
            end else if (mdl_cnt == 0) begin
                if (!mdl_hang) begin
                    rle_done    = 1'b1;
                    rle_size_in = rle_message_size >> 1;
                end
                mdl_cnt = -1;
            end
            if (rle_start === 1'b1) begin
                mdl_clr = 1'b1;
                start_cnt++;
            end
        end
        if (int'(queue_count) > max_count) max_count = int'(queue_count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] s,
                        input logic [31:0] r, input logic [3:0] t);
        int w;
        w            = 0;
        job_msg_addr = a;
        job_msg_size = s;
        job_rle_addr = r;
        job_tag      = t;
        job_valid    = 1'b1;
        while (job_ready !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        check("push_ready", job_ready, 1);
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_cmp(input int limit, output int n);
        n = 0;
        while (cmp_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic take_cmp();
        cmp_ready = 1'b1;
        tick();
        cmp_ready = 1'b0;
    endtask

    initial begin
        int  n;
        int  s;
        bit  stable;

        // Reset state
        repeat (3) tick();
        check("rst_nreset", rle_nreset, 0);
        check("rst_job_ready", job_ready, 0);
        check("rst_cmp_valid", cmp_valid, 0);
        check("rst_rle_start", rle_start, 0);
        check("rst_count", queue_count, 0);
        check("rst_busy", busy, 0);
        check("rst_jobs_done", jobs_done, 0);
        check("rst_cmp_tag", cmp_tag, 0);
        check("rst_cmp_err", cmp_err, 0);
        check("rst_msg_addr", rle_message_addr, 0);
        reset = 1'b0;
        #1;
        check("post_rst_job_ready", job_ready, 1);
        check("post_rst_nreset", rle_nreset, 1);

        // Test 1: single job, start two cycles after acceptance, done after 40 cycles
        mdl_delay = 40;
        push(32'h100, 32'd12, 32'h800, 4'd3);
        check("t1_no_early_start", rle_start, 0);
        check("t1_count", queue_count, 1);
        check("t1_busy", busy, 1);
        tick();
        check("t1_start", rle_start, 1);
        check("t1_msg_addr", rle_message_addr, 32'h100);
        check("t1_msg_size", rle_message_size, 32'd12);
        check("t1_rle_addr", rle_rle_addr, 32'h800);
        check("t1_count_popped", queue_count, 0);
        tick();
        check("t1_start_pulse", rle_start, 0);
        wait_cmp(200, n);
        check("t1_latency", n, 42);
        check("t1_tag", cmp_tag, 3);
        check("t1_size", cmp_rle_size, 6);
        check("t1_err", cmp_err, 0);
        take_cmp();
        check("t1_cmp_dropped", cmp_valid, 0);
        check("t1_jobs_done", jobs_done, 1);
        check("t1_starts", start_cnt, 1);

        // Test 4: zero-size job completes with no engine start
        push(32'h200, 32'd0, 32'h900, 4'd7);
        check("t4_not_yet", cmp_valid, 0);
        tick();
        check("t4_cmp_valid", cmp_valid, 1);
        check("t4_tag", cmp_tag, 7);
        check("t4_size", cmp_rle_size, 0);
        check("t4_no_start", rle_start, 0);
        take_cmp();
        check("t4_starts", start_cnt, 1);
        check("t4_jobs_done", jobs_done, 2);

        // Test 3: done still high from job 1 when the next job starts
        mdl_delay = 10;
        push(32'h300, 32'd40, 32'hA00, 4'd2);
        tick();
        check("t3_start", rle_start, 1);
        wait_cmp(200, n);
        check("t3_latency", n, 13);
        check("t3_tag", cmp_tag, 2);
        check("t3_size", cmp_rle_size, 20);
        take_cmp();
        check("t3_jobs_done", jobs_done, 3);

        // Test 2: five back-to-back jobs fill the 4-entry queue, then drain in order
        mdl_delay = 5;
        max_count = 0;
        for (int i = 0; i < 5; i++) begin
            push(32'h1000 + 32'(i) * 32'h10, 32'd20 + 32'(2 * i),
                 32'h2000 + 32'(i) * 32'h10, 4'(8 + i));
        end
        check("t2_full_count", queue_count, 4);
        check("t2_full_not_ready", job_ready, 0);
        job_msg_addr = 32'hDEAD;
        job_msg_size = 32'd2;
        job_tag      = 4'd15;
        job_valid    = 1'b1;
        tick();
        job_valid = 1'b0;
        check("t2_push_when_full", queue_count, 4);
        for (int i = 0; i < 5; i++) begin
            wait_cmp(200, n);
            check("t2_cmp_valid", cmp_valid, 1);
            check("t2_tag", cmp_tag, 32'(8 + i));
            check("t2_size", cmp_rle_size, 32'(10 + i));
            take_cmp();
        end
        check("t2_max_count", max_count, 4);
        check("t2_jobs_done", jobs_done, 8);
        check("t2_drained", queue_count, 0);
        check("t2_starts", start_cnt, 7);

        // Test 5: completion held under backpressure while the queue keeps filling
        mdl_delay = 3;
        push(32'h400, 32'd8, 32'hB00, 4'd4);
        push(32'h500, 32'd16, 32'hC00, 4'd5);
        wait_cmp(200, n);
        check("t5_a_tag", cmp_tag, 4);
        check("t5_a_size", cmp_rle_size, 4);
        s = start_cnt;
        push(32'h600, 32'd4, 32'hD00, 4'd6);
        check("t5_accept_during_stall", queue_count, 2);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cmp_valid !== 1'b1 || cmp_tag !== 4'd4 || cmp_rle_size !== 32'd4 ||
                rle_message_addr !== 32'h400)
                stable = 1'b0;
        end
        check("t5_stable", stable, 1);
        check("t5_no_launch", start_cnt, s);
        check("t5_queue_held", queue_count, 2);
        take_cmp();
        wait_cmp(200, n);
        check("t5_b_tag", cmp_tag, 5);
        check("t5_b_size", cmp_rle_size, 8);
        take_cmp();
        wait_cmp(200, n);
        check("t5_c_tag", cmp_tag, 6);
        check("t5_c_size", cmp_rle_size, 2);
        take_cmp();
        check("t5_jobs_done", jobs_done, 11);

        // Test 6: reset in WAIT with three jobs queued
        mdl_delay = 50;
        push(32'h700, 32'd10, 32'hE00, 4'd1);
        push(32'h710, 32'd10, 32'hE10, 4'd2);
        push(32'h720, 32'd10, 32'hE20, 4'd3);
        push(32'h730, 32'd10, 32'hE30, 4'd4);
        check("t6_queued", queue_count, 3);
        reset = 1'b1;
        #1;
        check("t6_nreset_low", rle_nreset, 0);
        tick();
        reset = 1'b0;
        #1;
        check("t6_count", queue_count, 0);
        check("t6_cmp_valid", cmp_valid, 0);
        check("t6_rle_start", rle_start, 0);
        check("t6_jobs_done", jobs_done, 0);
        check("t6_nreset_back", rle_nreset, 1);
        s = start_cnt;
        repeat (5) tick();
        check("t6_idle", busy, 0);
        check("t6_no_start", start_cnt, s);
        mdl_delay = 2;
        push(32'h100, 32'd6, 32'h880, 4'd9);
        wait_cmp(200, n);
        check("t6_after_tag", cmp_tag, 9);
        check("t6_after_size", cmp_rle_size, 3);
        take_cmp();
        check("t6_after_jobs_done", jobs_done, 1);

`ifdef RLE_SCHED_TIMEOUT_EN
        // Watchdog: engine never finishes, job is aborted after 100 WAIT cycles
        mdl_hang = 1'b1;
        push(32'h800, 32'd10, 32'hF00, 4'd11);
        tick();
        check("to_start", rle_start, 1);
        n = 0;
        while (rle_nreset === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("to_latency", n, 102);
        check("to_nreset_1", rle_nreset, 0);
        check("to_no_cmp", cmp_valid, 0);
        tick();
        check("to_nreset_2", rle_nreset, 0);
        tick();
        check("to_nreset_release", rle_nreset, 1);
        check("to_cmp_valid", cmp_valid, 1);
        check("to_err", cmp_err, 1);
        check("to_size", cmp_rle_size, 0);
        check("to_tag", cmp_tag, 11);
        take_cmp();
        check("to_jobs_done", jobs_done, 2);
        mdl_hang = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
